// File: rtl/led_matrix_pkg.sv
// Shared geometry, types and helpers for the 5x7 LED matrix scan logic.
package led_matrix_pkg;

  localparam int MATRIX_COLS = 5;
  localparam int MATRIX_ROWS = 7;
  localparam int FRAME_BITS  = MATRIX_COLS * MATRIX_ROWS;
  localparam int COL_SEL_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_e;

  typedef logic [FRAME_BITS-1:0]  frame_t;
  typedef logic [MATRIX_ROWS-1:0] row_t;
  typedef logic [MATRIX_COLS-1:0] col_en_t;
  typedef logic [COL_SEL_W-1:0]   col_sel_t;

  // Row-value multiplexer: frame bit index is col*7 + row.
  function automatic row_t row_mux(frame_t frame, col_sel_t sel);
    row_t result;
    case (sel)
      3'd0:    result = frame[0*MATRIX_ROWS +: MATRIX_ROWS];
      3'd1:    result = frame[1*MATRIX_ROWS +: MATRIX_ROWS];
      3'd2:    result = frame[2*MATRIX_ROWS +: MATRIX_ROWS];
      3'd3:    result = frame[3*MATRIX_ROWS +: MATRIX_ROWS];
      3'd4:    result = frame[4*MATRIX_ROWS +: MATRIX_ROWS];
      default: result = '0;
    endcase
    return result;
  endfunction

  function automatic col_en_t col_onehot(col_sel_t sel);
    col_en_t result;
    result = '0;
    if (sel < COL_SEL_W'(MATRIX_COLS)) begin
      result = col_en_t'(1) << sel;
    end
    return result;
  endfunction

endpackage

// File: rtl/led_matrix_scan_ctrl_if.sv
// Frame-update and matrix-drive signals between the status logic and the scan controller.
interface led_matrix_scan_ctrl_if;

  logic                         enable;
  led_matrix_pkg::frame_t       frame_in;
  logic                         frame_load;
  logic                         frame_pending;
  led_matrix_pkg::col_sel_t     col_sel;
  led_matrix_pkg::col_en_t      col_en;
  led_matrix_pkg::row_t         row_data;
  logic                         frame_start;

  // System side: supplies images and the enable, watches the matrix drive.
  modport master (
    output enable,
    output frame_in,
    output frame_load,
    input  frame_pending,
    input  col_sel,
    input  col_en,
    input  row_data,
    input  frame_start
  );

  // Scan controller side.
  modport slave (
    input  enable,
    input  frame_in,
    input  frame_load,
    output frame_pending,
    output col_sel,
    output col_en,
    output row_data,
    output frame_start
  );

endinterface

// File: rtl/led_frame_dbuf.sv
// Shadow/active image pair: loads land in the shadow, swap to active only at a frame boundary.
module led_frame_dbuf
  import led_matrix_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load_i,
  input  frame_t load_data_i,
  input  logic   swap_i,
  output frame_t active_o,
  output logic   pending_o
);

  frame_t shadow_q, shadow_d;
  frame_t active_q, active_d;
  logic   pending_q, pending_d;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path holds a value and no latch is inferred.
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;

    if (swap_i && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end

    // Evaluated after the swap so a load on the swap edge keeps the flag set.
    if (load_i) begin
      shadow_d  = load_data_i;
      pending_d = 1'b1;
    end
  end

  // NOTE: the image registers are reset too, so the matrix powers up dark instead of showing stale bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  assign active_o  = active_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// Column scan controller for the 5x7 matrix: blank/show sequencing with tear-free image updates.
module led_matrix_scan_ctrl
  import led_matrix_pkg::*;
#(
  parameter int SHOW_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int NUM_COLS     = MATRIX_COLS
) (
  input logic clk,
  input logic reset,
  led_matrix_scan_ctrl_if.slave bus
);

  localparam int MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam col_sel_t         LAST_COL   = COL_SEL_W'(NUM_COLS - 1);

  scan_state_e      state_q, state_d;
  col_sel_t         col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  col_en_t          col_en_q, col_en_d;
  row_t             row_q, row_d;
  logic             frame_start_q, frame_start_d;

  frame_t active;
  logic   pending;
  logic   swap;

  // Swap depends only on the scan position, so it still completes if enable drops on that cycle.
  assign swap = (state_q == ST_SHOW) && (col_q == LAST_COL) && (cnt_q == SHOW_LAST);

  led_frame_dbuf u_dbuf (
    .clk         (clk),
    .reset       (reset),
    .load_i      (bus.frame_load),
    .load_data_i (bus.frame_in),
    .swap_i      (swap),
    .active_o    (active),
    .pending_o   (pending)
  );

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    cnt_d         = cnt_q;
    col_en_d      = '0;
    row_d         = '0;
    frame_start_d = 1'b0;

    if (!bus.enable) begin
      state_d = ST_IDLE;
      col_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          col_d   = '0;
          cnt_d   = '0;
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            col_d   = (col_q == LAST_COL) ? '0 : col_q + COL_SEL_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          col_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end

    // Drive values are decoded from the next state so they switch on the same edge as the FSM.
    if (state_d == ST_SHOW) begin
      col_en_d      = col_onehot(col_d);
      row_d         = row_mux(active, col_d);
      frame_start_d = (state_q != ST_SHOW) && (col_d == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      col_q         <= '0;
      cnt_q         <= '0;
      col_en_q      <= '0;
      row_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      cnt_q         <= cnt_d;
      col_en_q      <= col_en_d;
      row_q         <= row_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.col_sel       = col_q;
  assign bus.col_en        = col_en_q;
  assign bus.row_data      = row_q;
  assign bus.frame_start   = frame_start_q;
  assign bus.frame_pending = pending;

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Scoreboard bench: stimulus queues expected column displays, a negedge monitor compares each lit column.
module tb_led_matrix_scan_ctrl;
  import led_matrix_pkg::*;

  localparam int SHOW   = 4;
  localparam int BLANK  = 1;
  localparam int PERIOD = 5 * (SHOW + BLANK);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  led_matrix_scan_ctrl_if bus ();

  led_matrix_scan_ctrl #(
    .SHOW_CYCLES  (SHOW),
    .BLANK_CYCLES (BLANK),
    .NUM_COLS     (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int         col;
    logic [6:0] row;
    logic       fs;
    int         len;
    bit         chk_gap;
    bit         restart;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_on  = 1'b0;

  frame_t f_zero, f_ones, f_a, f_b, f_c, f_d, tmp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic push_frame(input frame_t f, input bit restart, input int ncols, input int last_len);
    for (int c = 0; c < ncols; c++) begin
      exp_t e;
      e.col     = c;
      e.row     = f[c*7 +: 7];
      e.fs      = (c == 0);
      e.len     = (c == ncols - 1) ? last_len : SHOW;
      e.chk_gap = !(restart && c == 0);
      e.restart = restart;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_show(input int c);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.col_en == (5'd1 << c)) return;
    end
    timeout_fail($sformatf("wait_show_col%0d", c));
  endtask

  task automatic wait_fs();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.frame_start) return;
    end
    timeout_fail("wait_frame_start");
  endtask

  task automatic load_frame(input frame_t f);
    bus.frame_in   = f;
    bus.frame_load = 1'b1;
    @(negedge clk);
    bus.frame_load = 1'b0;
  endtask

  // Monitor state
  int         cyc = 0;
  bit         in_run = 1'b0;
  int         gap = 0;
  bit         dark_bad = 1'b0;
  bit         sel_bad = 1'b0;
  int         run_sel, run_len, run_gap, run_start;
  logic [4:0] run_en;
  logic [6:0] run_row;
  logic       run_fs, run_fs_later, run_changed, run_dark_bad;
  bit         have_prev_fs = 1'b0;
  int         prev_fs_cyc = 0;
  exp_t       me;

  always @(negedge clk) begin
    if (mon_on) begin
      cyc++;
      if (bus.col_sel > 3'd4) sel_bad = 1'b1;
      if (bus.col_en != 5'd0) begin
        if (!in_run) begin
          in_run       = 1'b1;
          run_sel      = int'(bus.col_sel);
          run_en       = bus.col_en;
          run_row      = bus.row_data;
          run_fs       = bus.frame_start;
          run_fs_later = 1'b0;
          run_changed  = 1'b0;
          run_len      = 1;
          run_gap      = gap;
          run_start    = cyc;
          run_dark_bad = dark_bad;
          dark_bad     = 1'b0;
        end else begin
          run_len++;
          if (int'(bus.col_sel) != run_sel || bus.col_en != run_en || bus.row_data != run_row)
            run_changed = 1'b1;
          run_fs_later = run_fs_later | bus.frame_start;
        end
      end else begin
        if (bus.row_data != 7'd0 || bus.frame_start) dark_bad = 1'b1;
        if (in_run) begin
          in_run = 1'b0;
          gap    = 0;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_column: got col %0d with nothing expected", run_sel);
          end else begin
            me = exp_q.pop_front();
            check($sformatf("col_sel_c%0d", me.col), 64'(run_sel), 64'(me.col));
            check($sformatf("col_en_c%0d", me.col), 64'(run_en), 64'(5'd1 << me.col));
            check($sformatf("row_data_c%0d", me.col), 64'(run_row), 64'(me.row));
            check($sformatf("frame_start_c%0d", me.col), 64'({run_fs, run_fs_later}), 64'({me.fs, 1'b0}));
            check($sformatf("show_len_c%0d", me.col), 64'(run_len), 64'(me.len));
            check($sformatf("stable_dark_c%0d", me.col), 64'({run_changed, run_dark_bad, sel_bad}), 64'(0));
            if (me.chk_gap)
              check($sformatf("blank_gap_c%0d", me.col), 64'(run_gap), 64'(BLANK));
            if (me.col == 0) begin
              if (have_prev_fs && !me.restart)
                check("frame_period", 64'(run_start - prev_fs_cyc), 64'(PERIOD));
              have_prev_fs = 1'b1;
              prev_fs_cyc  = run_start;
            end
          end
        end
        gap++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    f_zero = '0;
    f_ones = '1;
    f_a    = 35'h1_2345_6789;
    f_b    = 35'h6_0F0F_3C3C;
    f_c    = 35'h2_468A_CE13;
    f_d    = 35'h5_A5A5_5A5A;

    reset          = 1'b1;
    bus.enable     = 1'b0;
    bus.frame_in   = '0;
    bus.frame_load = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col_en",   64'(bus.col_en), 64'(0));
    check("rst_row_data", 64'(bus.row_data), 64'(0));
    check("rst_col_sel",  64'(bus.col_sel), 64'(0));
    check("rst_fs",       64'(bus.frame_start), 64'(0));
    check("rst_pending",  64'(bus.frame_pending), 64'(0));

    // Enable: one BLANK cycle, then column 0 lit with frame_start
    reset      = 1'b0;
    bus.enable = 1'b1;
    @(negedge clk);
    check("en_blank_col_en",  64'(bus.col_en), 64'(0));
    check("en_blank_col_sel", 64'(bus.col_sel), 64'(0));
    @(negedge clk);
    check("en_show_col_en", 64'(bus.col_en), 64'(5'b00001));
    check("en_show_fs",     64'(bus.frame_start), 64'(1));
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_col_en", 64'(bus.col_en), 64'(0));
    check("async_rst_fs_sel", 64'({bus.frame_start, bus.col_sel}), 64'(0));
    bus.enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mon_on = 1'b1;

    // Full scan of the blank image, then tear-free swap to all-ones
    push_frame(f_zero, 1'b1, 5, SHOW);
    bus.enable = 1'b1;
    wait_show(2);
    load_frame(f_ones);
    check("pending_after_load", 64'(bus.frame_pending), 64'(1));
    push_frame(f_ones, 1'b0, 5, SHOW);
    wait_show(4);
    repeat (3) @(negedge clk);
    check("pending_last_show", 64'(bus.frame_pending), 64'(1));
    @(negedge clk);
    check("pending_cleared", 64'(bus.frame_pending), 64'(0));

    // Double load A then B, then C on the swap cycle
    wait_show(1);
    load_frame(f_a);
    wait_show(2);
    load_frame(f_b);
    push_frame(f_b, 1'b0, 5, SHOW);
    wait_show(4);
    repeat (3) @(negedge clk);
    load_frame(f_c);
    check("pending_load_on_swap", 64'(bus.frame_pending), 64'(1));
    push_frame(f_c, 1'b0, 4, 2);
    wait_fs();
    wait_fs();
    check("pending_after_c_swap", 64'(bus.frame_pending), 64'(0));

    // Enable drop mid-SHOW of column 3 with D pending
    wait_show(2);
    load_frame(f_d);
    wait_show(3);
    @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    check("drop_col_en",   64'(bus.col_en), 64'(0));
    check("drop_row_data", 64'(bus.row_data), 64'(0));
    check("drop_col_sel",  64'(bus.col_sel), 64'(0));
    check("drop_pending",  64'(bus.frame_pending), 64'(1));
    repeat (4) @(negedge clk);

    push_frame(f_c, 1'b1, 5, SHOW);
    push_frame(f_d, 1'b0, 5, SHOW);
    bus.enable = 1'b1;
    @(negedge clk);
    check("reen_blank_col_en",  64'(bus.col_en), 64'(0));
    check("reen_blank_col_sel", 64'(bus.col_sel), 64'(0));
    @(negedge clk);
    tmp = f_c;
    check("reen_show_col_en", 64'(bus.col_en), 64'(5'b00001));
    check("reen_show_fs",     64'(bus.frame_start), 64'(1));
    check("reen_show_row",    64'(bus.row_data), 64'(tmp[6:0]));

    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    check("final_pending", 64'(bus.frame_pending), 64'(0));
    mon_on     = 1'b0;
    bus.enable = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
